// File: rtl/fp8_addsub_align_stage.sv
// fp8_addsub_align_stage: FP8 operand unpack, magnitude ordering and close/far path select with skid buffer
module fp8_addsub_align_stage #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              close_sel,
  output logic              sign_res,
  output logic [MAN_W:0]    fraca_c,
  output logic [MAN_W:0]    fracb_c,
  output logic [EXP_W-1:0]  exp_large,
  output logic [EXP_W-1:0]  exp_diff,
  output logic              one_d,
  output logic              eff_sub,
  output logic [CNT_W-1:0]  close_cnt
);
  localparam int FRAC_W = MAN_W + 1;
  localparam int W = EXP_W + MAN_W + 1;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE = 2'b01;
  localparam logic [1:0] FULL = 2'b10;
  typedef struct packed {
    logic              close_sel;
    logic              sign_res;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    logic [EXP_W-1:0]  el;
    logic [EXP_W-1:0]  ed;
    logic              one_d;
    logic              eff_sub;
  } bnd_t;
  logic [1:0] st_q, st_d;
  bnd_t r_q, r_d, s_q, s_d, nb;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_big, b_sign, in_x, out_x;
  // Unpack both operands and build the ordered bundle for the incoming pair
  always_comb begin
    ea = (op_a[W-2:MAN_W] == '0) ? EXP_W'(1) : op_a[W-2:MAN_W];
    eb = (op_b[W-2:MAN_W] == '0) ? EXP_W'(1) : op_b[W-2:MAN_W];
    fa = {|op_a[W-2:MAN_W], op_a[MAN_W-1:0]};
    fb = {|op_b[W-2:MAN_W], op_b[MAN_W-1:0]};
    a_big = (ea > eb) | ((ea == eb) & (fa >= fb));
    b_sign = op_b[W-1] ^ sub;
    nb.eff_sub = op_a[W-1] ^ b_sign;
    nb.fa = a_big ? fa : fb;
    nb.fb = a_big ? fb : fa;
    nb.el = a_big ? ea : eb;
    nb.ed = a_big ? ea - eb : eb - ea;
    nb.one_d = nb.ed == EXP_W'(1);
    nb.close_sel = nb.eff_sub & (nb.ed <= EXP_W'(1));
    nb.sign_res = (nb.eff_sub & (ea == eb) & (fa == fb)) ? 1'b0 : (a_big ? op_a[W-1] : b_sign);
  end
  assign in_ready = ~st_q[1];
  assign out_valid = |st_q;
  assign in_x = in_valid & in_ready;
  assign out_x = out_valid & out_ready;
  // Next-state for main/skid slots and the saturating close-path counter
  always_comb begin
    st_d = st_q;
    r_d = r_q;
    s_d = s_q;
    if (st_q == EMPTY) begin
      if (in_x) begin
        r_d = nb;
        st_d = ONE;
      end
    end else if (st_q == ONE) begin
      if (in_x & out_x) r_d = nb;
      else if (in_x) begin
        s_d = nb;
        st_d = FULL;
      end else if (out_x) st_d = EMPTY;
    end else if (out_x) begin
      r_d = s_q;
      st_d = ONE;
    end
    cnt_d = (in_x & nb.close_sel & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // State registers, cleared asynchronously so in-flight bundles are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= EMPTY;
      r_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      r_q <= r_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
    end
  end
  assign close_sel = r_q.close_sel;
  assign sign_res = r_q.sign_res;
  assign fraca_c = r_q.fa;
  assign fracb_c = r_q.fb;
  assign exp_large = r_q.el;
  assign exp_diff = r_q.ed;
  assign one_d = r_q.one_d;
  assign eff_sub = r_q.eff_sub;
  assign close_cnt = cnt_q;
endmodule

// File: tb/tb_fp8_addsub_align_stage.sv
// tb_fp8_addsub_align_stage: randomized and directed checks of the FP8 align stage against a value-level model
module tb_fp8_addsub_align_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 0;
  logic [7:0] op_a = 0, op_b = 0;
  logic in_ready, out_valid, close_sel, sign_res, one_d, eff_sub;
  logic [3:0] fraca_c, fracb_c, exp_large, exp_diff;
  logic [15:0] close_cnt;
  logic s_ir, s_ov, s_cs, s_sr, s_od, s_es;
  logic [3:0] s_fa, s_fb, s_el, s_ed;
  logic [2:0] cnt_s;
  logic [19:0] obus;
  logic [19:0] q[$];
  int ncmp = 0, nerr = 0, mcnt = 0, sent;
  bit saw_full;
  always #5 clk = ~clk;
  fp8_addsub_align_stage dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .close_sel(close_sel), .sign_res(sign_res), .fraca_c(fraca_c), .fracb_c(fracb_c),
    .exp_large(exp_large), .exp_diff(exp_diff), .one_d(one_d), .eff_sub(eff_sub), .close_cnt(close_cnt));
  fp8_addsub_align_stage #(.CNT_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(s_ov), .out_ready(out_ready),
    .close_sel(s_cs), .sign_res(s_sr), .fraca_c(s_fa), .fracb_c(s_fb),
    .exp_large(s_el), .exp_diff(s_ed), .one_d(s_od), .eff_sub(s_es), .close_cnt(cnt_s));
  assign obus = {close_sel, sign_res, fraca_c, fracb_c, exp_large, exp_diff, one_d, eff_sub};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [19:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int xa, xb, ma, mb, fl, fs, xl, xs;
    bit es, sb, abig, close, sg;
    xa = (a[6:3] == 0) ? 1 : int'(a[6:3]);
    xb = (b[6:3] == 0) ? 1 : int'(b[6:3]);
    ma = ((a[6:3] != 0) ? 8 : 0) + int'(a[2:0]);
    mb = ((b[6:3] != 0) ? 8 : 0) + int'(b[2:0]);
    es = a[7] ^ b[7] ^ s;
    sb = b[7] ^ s;
    abig = (ma << xa) >= (mb << xb);
    fl = abig ? ma : mb; fs = abig ? mb : ma;
    xl = abig ? xa : xb; xs = abig ? xb : xa;
    close = es && (xl - xs) <= 1;
    sg = (es && (ma << xa) == (mb << xb)) ? 1'b0 : (abig ? a[7] : sb);
    return {close, sg, 4'(fl), 4'(fs), 4'(xl), 4'(xl - xs), (xl - xs) == 1, es};
  endfunction
  task automatic cyc();
    bit ix, ox;
    logic [19:0] e;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    chk("close_cnt", close_cnt, mcnt);
    chk("close_cnt_sat", cnt_s, (mcnt > 7) ? 7 : mcnt);
    if (in_ready == 0) saw_full = 1;
    if (ox && q.size() != 0) begin
      chk("bundle", obus, q[0]);
      void'(q.pop_front());
    end
    if (ix) begin
      e = ref_model(op_a, op_b, sub);
      q.push_back(e);
      if (e[19]) mcnt++;
    end
    @(posedge clk); #1;
  endtask
  task automatic one(input logic [7:0] a, input logic [7:0] b, input logic s);
    in_valid = 1; op_a = a; op_b = b; sub = s; out_ready = 1;
    cyc();
    in_valid = 0;
  endtask
  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", obus, 0);
    chk("rst_cnt", close_cnt, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    one(8'h3C, 8'h3A, 1);
    chk("t1_close", close_sel, 1); chk("t1_fa", fraca_c, 4'b1100); chk("t1_fb", fracb_c, 4'b1010);
    chk("t1_el", exp_large, 7); chk("t1_oned", one_d, 0); chk("t1_sign", sign_res, 0);
    cyc();
    one(8'h40, 8'h3C, 1);
    chk("t2_close", close_sel, 1); chk("t2_oned", one_d, 1); chk("t2_fa", fraca_c, 4'b1000);
    chk("t2_fb", fracb_c, 4'b1100); chk("t2_el", exp_large, 8); chk("t2_ed", exp_diff, 1);
    cyc();
    one(8'h3A, 8'h3C, 1);
    chk("t3_fa", fraca_c, 4'b1100); chk("t3_fb", fracb_c, 4'b1010); chk("t3_sign", sign_res, 1);
    cyc();
    one(8'h3C, 8'h3C, 1);
    chk("t4_sign", sign_res, 0); chk("t4_close", close_sel, 1);
    cyc();
    one(8'h48, 8'h38, 0);
    chk("t5_close", close_sel, 0); chk("t5_effsub", eff_sub, 0); chk("t5_ed", exp_diff, 2); chk("t5_el", exp_large, 9);
    cyc();
    one(8'h01, 8'h00, 0);
    chk("t6_el", exp_large, 1); chk("t6_ed", exp_diff, 0); chk("t6_fa", fraca_c, 4'b0001); chk("t6_fb", fracb_c, 4'b0000);
    cyc();
    sent = 0; saw_full = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = sent < 8; out_ready = !(i >= 3 && i < 6);
      op_a = 8'($urandom); op_b = 8'($urandom); sub = 1'($urandom);
      if (in_valid && in_ready) sent++;
      cyc();
    end
    chk("stream_sent", sent, 8);
    chk("stream_stall_seen", saw_full, 1);
    chk("stream_drained", q.size(), 0);
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      op_a = 8'($urandom); op_b = 8'($urandom); sub = 1'($urandom);
      if ($urandom_range(0, 3) == 0) op_b = {op_b[7], op_a[6:3], op_b[2:0]};
      cyc();
    end
    in_valid = 1; out_ready = 0; op_a = 8'h3C; op_b = 8'h3A; sub = 1;
    cyc(); cyc();
    chk("full_in_ready", in_ready, 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_cnt", close_cnt, 0);
    chk("arst_cnt_s", cnt_s, 0);
    chk("arst_data", obus, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete(); mcnt = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; out_ready = 1; op_a = 8'h3C; op_b = 8'h3A; sub = 1;
      cyc();
    end
    in_valid = 0;
    cyc(); cyc();
    chk("sat_cnt_s", cnt_s, 3'h7);
    chk("sat_cnt", close_cnt, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
